// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchronizer, counter-based debounce, press/release
// edge pulses and a hold-to-repeat FSM whose Step output feeds a downstream counter.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic Button,
  output logic Level,
  output logic Press,
  output logic Release,
  output logic Repeat,
  output logic Step
);

  localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW   = $clog2(RptMax + 1);

  typedef enum logic [1:0] {
    StIdle,
    StHoldDelay,
    StHoldRepeat
  } state_e;

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] db_cnt_q;
  logic [RptW-1:0] rpt_cnt_q;
  state_e          state_q;

  logic db_done, rise, fall, rpt_fire;

  // Level flips once the mismatch has persisted with the counter already at its limit.
  assign db_done = (sync2_q != Level) && (db_cnt_q == CntW'(DEBOUNCE_CYCLES));
  assign rise    = db_done & ~Level;
  assign fall    = db_done & Level;

  always_comb begin
    rpt_fire = 1'b0;
    unique case (state_q)
      StHoldDelay:  rpt_fire = (rpt_cnt_q == RptW'(REPEAT_DELAY));
      StHoldRepeat: rpt_fire = (rpt_cnt_q == RptW'(REPEAT_PERIOD));
      default:      rpt_fire = 1'b0;
    endcase
    // Never repeat in the cycle the release is accepted.
    if (fall) rpt_fire = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_cnt_q  <= '0;
      rpt_cnt_q <= '0;
      state_q   <= StIdle;
      Level     <= 1'b0;
      Press     <= 1'b0;
      Release   <= 1'b0;
      Repeat    <= 1'b0;
      Step      <= 1'b0;
    end else begin
      sync1_q <= Button;
      sync2_q <= sync1_q;

      if ((sync2_q == Level) || db_done) begin
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
      if (db_done) Level <= ~Level;

      Press   <= rise;
      Release <= fall;
      Repeat  <= rpt_fire;
      Step    <= rise | rpt_fire;

      // rpt_cnt_q holds cycles elapsed since the last Press or Repeat.
      if (rise) begin
        state_q   <= (REPEAT_DELAY != 0) ? StHoldDelay : StIdle;
        rpt_cnt_q <= RptW'(1);
      end else if (fall || !Level) begin
        state_q   <= StIdle;
        rpt_cnt_q <= '0;
      end else begin
        unique case (state_q)
          StHoldDelay: begin
            if (rpt_fire) begin
              state_q   <= StHoldRepeat;
              rpt_cnt_q <= RptW'(1);
            end else begin
              rpt_cnt_q <= rpt_cnt_q + 1'b1;
            end
          end
          StHoldRepeat: begin
            if (rpt_fire) begin
              rpt_cnt_q <= RptW'(1);
            end else begin
              rpt_cnt_q <= rpt_cnt_q + 1'b1;
            end
          end
          default: rpt_cnt_q <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with short timing parameters; a second instance
// with auto-repeat disabled runs on the same stimulus.
module tb_button_debounce;

  localparam int unsigned Db = 4;
  localparam int unsigned Rd = 10;
  localparam int unsigned Rp = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button = 1'b0;
  logic lvl, prs, rel, rpt, stp;
  logic lvl2, prs2, rel2, rpt2, stp2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic b;
    logic lvl;
    logic prs;
    logic rel;
  } vec_t;

  vec_t tbl [25];

  always #5 clk = ~clk;

  button_debounce #(
    .DEBOUNCE_CYCLES(Db),
    .REPEAT_DELAY   (Rd),
    .REPEAT_PERIOD  (Rp)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .Button (button),
    .Level  (lvl),
    .Press  (prs),
    .Release(rel),
    .Repeat (rpt),
    .Step   (stp)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(Db),
    .REPEAT_DELAY   (0),
    .REPEAT_PERIOD  (Rp)
  ) dut_norpt (
    .CLK    (clk),
    .RST    (rst),
    .Button (button),
    .Level  (lvl2),
    .Press  (prs2),
    .Release(rel2),
    .Repeat (rpt2),
    .Step   (stp2)
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic el, input logic ep, input logic er,
                           input logic erp);
    check({name, ".level"},   lvl, el);
    check({name, ".press"},   prs, ep);
    check({name, ".release"}, rel, er);
    check({name, ".repeat"},  rpt, erp);
    check({name, ".step"},    stp, ep | erp);
  endtask

  // One clock edge, then sample; invariants checked every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    check("at_most_one_pulse", ($countones({prs, rel, rpt}) <= 1), 1'b1);
    check("norpt.repeat", rpt2, 1'b0);
    check("norpt.step_eq_press", stp2, prs2);
  endtask

  // From a settled low level: drive high and expect Press exactly 6 edges later.
  task automatic press_seq(input string name);
    button = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      check_out(name, (k == 6), (k == 6), 1'b0, 1'b0);
    end
  endtask

  initial begin
    tbl = '{
      '{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0, 1'b0}
    };

    rst = 1'b1;
    button = 1'b0;
    tick();
    tick();
    check_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Clean press, release and a 3-cycle glitch.
    for (int i = 0; i < 25; i++) begin
      button = tbl[i].b;
      tick();
      check_out($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].prs, tbl[i].rel, 1'b0);
    end

    // Bounce: toggle every 2 cycles for 20 cycles, then hold.
    for (int i = 0; i < 20; i++) begin
      button = ((i / 2) % 2 == 0);
      tick();
      check("bounce.press", prs, 1'b0);
      check("bounce.level", lvl, 1'b0);
    end
    press_seq("bounce_hold");

    // Release accepted during the repeat delay (Release at t+8).
    for (int j = 1; j <= 14; j++) begin
      button = (j == 1);
      tick();
      check_out($sformatf("rel_delay%0d", j), (j < 8), 1'b0, (j == 8), 1'b0);
    end

    // Auto-repeat; release at t+37 coincides with a would-be repeat slot.
    press_seq("rpt_press");
    for (int k = 1; k <= 41; k++) begin
      button = (k <= 30);
      tick();
      check_out($sformatf("rpt%0d", k), (k < 37), 1'b0, (k == 37),
                (k >= 10) && (k < 37) && ((k - 10) % 3 == 0));
    end

    // Reset mid-hold at t+12 with the button still down.
    press_seq("hold_press");
    for (int k = 1; k <= 11; k++) begin
      tick();
      check_out($sformatf("hold%0d", k), 1'b1, 1'b0, 1'b0, (k == 10));
    end
    rst = 1'b1;
    tick();
    check_out("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int j = 0; j <= 6; j++) begin
      tick();
      check_out($sformatf("post_rst%0d", j), (j == 6), (j == 6), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
